// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction prefetch over a valid/ready imem port, in-order prefetch FIFO, redirect flush.
// Latency: reset release or FLUSH to first out_valid is 2 + L cycles (1 + L with FETCH_BYPASS_EN defined).
// Backpressure: out_ready low fills the FIFO; requests stop once fifo_count + outstanding reaches FIFO_DEPTH.
// Optional macro FETCH_BYPASS_EN forwards a response straight to out_* when the FIFO is empty.

// Small synchronous FIFO with flush; DEPTH must be a power of two so pointers wrap naturally.
module fetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   clr_i,
  input  logic                   push_i,
  input  logic [W-1:0]           wdata_i,
  input  logic                   pop_i,
  output logic [W-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push_ok, pop_ok;

  // Pointer/count next state; a push at full is accepted only alongside a pop, clear wins.
  always_comb begin
    pop_ok  = pop_i && (cnt_q != '0);
    push_ok = push_i && ((cnt_q != FULL_CNT) || pop_ok);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (clr_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push_ok) wr_d = wr_q + AW'(1);
      if (pop_ok)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage write; contents need no reset because the count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok && !clr_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign count_o = cnt_q;
endmodule

module fetch_unit #(
  parameter int                    ADDR_WIDTH = 64,
  parameter int                    INST_WIDTH = 32,
  parameter int                    FIFO_DEPTH = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 64'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [INST_WIDTH-1:0] imem_resp_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [INST_WIDTH-1:0] out_inst
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_FLUSH} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]         outst_q, outst_d;
  logic [CW-1:0]         drop_q, drop_d;

  logic                             redir, req_fire, resp_ok, resp_keep, byp;
  logic                             fifo_push, fifo_pop, fifo_empty;
  logic [CW-1:0]                    fifo_cnt, tag_cnt;
  logic [CW:0]                      credit_sum;
  logic [ADDR_WIDTH+INST_WIDTH-1:0] fifo_head;
  logic [ADDR_WIDTH-1:0]            tag_head, head_pc;
  logic [INST_WIDTH-1:0]            head_inst;

  // Prefetched {pc, inst} entries waiting for decode.
  fetch_fifo #(.W(ADDR_WIDTH + INST_WIDTH), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clr_i   (redir),
    .push_i  (fifo_push),
    .wdata_i ({tag_head, imem_resp_data}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .count_o (fifo_cnt)
  );

  // PCs of live (non-dropped) in-flight requests, oldest at the head.
  fetch_fifo #(.W(ADDR_WIDTH), .DEPTH(FIFO_DEPTH)) u_tag_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .clr_i   (redir),
    .push_i  (req_fire),
    .wdata_i (fetch_pc_q),
    .pop_i   (resp_keep),
    .rdata_o (tag_head),
    .count_o (tag_cnt)
  );

  // FSM next state: one BOOT cycle, then FETCH; any redirect (re)enters FLUSH for a cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_BOOT:  state_d = S_FETCH;
      S_FETCH: if (redirect_valid) state_d = S_FLUSH;
      S_FLUSH: state_d = redirect_valid ? S_FLUSH : S_FETCH;
      default: state_d = S_BOOT;
    endcase
  end

  // Request credit, response steering, output selection and counter next state.
  always_comb begin
    redir          = redirect_valid && (state_q != S_BOOT);
    credit_sum     = {1'b0, fifo_cnt} + {1'b0, outst_q};
    imem_req_valid = (state_q == S_FETCH) && !redirect_valid && (credit_sum < CREDIT_MAX);
    imem_req_addr  = imem_req_valid ? fetch_pc_q : '0;
    req_fire       = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding belongs to a pre-reset request and is ignored.
    resp_ok        = imem_resp_valid && (outst_q != '0);
    resp_keep      = resp_ok && (drop_q == '0) && (tag_cnt != '0);
    fifo_empty     = (fifo_cnt == '0);
`ifdef FETCH_BYPASS_EN
    byp            = fifo_empty && resp_keep;
`else
    byp            = 1'b0;
`endif
    head_pc   = byp ? tag_head : fifo_head[ADDR_WIDTH+INST_WIDTH-1:INST_WIDTH];
    head_inst = byp ? imem_resp_data : fifo_head[INST_WIDTH-1:0];
    out_valid = !redir && (!fifo_empty || byp);
    out_pc    = out_valid ? head_pc : '0;
    out_inst  = out_valid ? head_inst : '0;
    // A bypassed entry taken by decode this cycle never enters the FIFO.
    fifo_push = resp_keep && !(byp && out_ready);
    fifo_pop  = out_valid && out_ready && !fifo_empty;

    outst_d    = outst_q + CW'(req_fire) - CW'(resp_ok);
    drop_d     = drop_q;
    fetch_pc_d = fetch_pc_q;
    if (resp_ok && (drop_q != '0)) drop_d = drop_q - CW'(1);
    if (req_fire) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(4);
    if (redir) begin
      // Everything still in flight after this edge is stale.
      fetch_pc_d = redirect_pc & ~ADDR_WIDTH'(1);
      drop_d     = outst_d;
    end
  end

  // State, fetch PC and credit counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit with an in-order latency memory model.
// Latency: memory latency per phase (fixed 1 or 3, random 1..4 in the random phase).
// Backpressure: out_ready and imem_req_ready are driven from the stimulus process.
module tb_fetch_unit;
  localparam int          AW     = 64;
  localparam int          IW     = 32;
  localparam int          DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h8000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          imem_req_valid;
  logic          imem_req_ready;
  logic [AW-1:0] imem_req_addr;
  logic          imem_resp_valid;
  logic [IW-1:0] imem_resp_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_pc;
  logic [IW-1:0] out_inst;

  fetch_unit #(.ADDR_WIDTH(AW), .INST_WIDTH(IW), .FIFO_DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_inst        (out_inst)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [63:0] pc; logic [31:0] inst;} exp_t;
  typedef struct packed {logic [31:0] data; int due;} mresp_t;

  int          vectors     = 0;
  int          miscompares = 0;
  exp_t        exp_q[$];
  mresp_t      pend_q[$];
  logic [63:0] req_exp_pc  = RST_PC;
  int          mem_lat     = 1;   // 0 selects a random latency per request
  int          cyc         = 0;
  int          acc_cnt     = 0;
  int          out_cnt     = 0;

  // Program image: every address holds a scrambled function of itself.
  function automatic logic [31:0] mem_word(input logic [63:0] pc);
    logic [63:0] h;
    h = pc * 64'h9E37_79B9_7F4A_7C15;
    return h[63:32] ^ pc[31:0];
  endfunction

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected decode stream from a start address: consecutive words, +4 each, wrapping at 2^64.
  task automatic load_stream(input logic [63:0] start);
    exp_t e;
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      e.pc   = start + 64'(4 * i);
      e.inst = mem_word(e.pc);
      exp_q.push_back(e);
    end
  endtask

  task automatic redirect(input logic [63:0] tgt);
    @(posedge clk); #1;
    redirect_valid = 1'b1;
    redirect_pc    = tgt;
    load_stream(tgt & ~64'd1);
    req_exp_pc     = tgt & ~64'd1;
  endtask

  task automatic end_redirect();
    @(posedge clk); #1;
    redirect_valid = 1'b0;
  endtask

  // In-order memory: accepts at the edge, answers L cycles later, one response per cycle.
  initial begin : mem_model
    int lat;
    mresp_t r;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    forever begin
      @(negedge clk);
      if (rst && imem_req_valid && imem_req_ready) begin
        acc_cnt++;
        check("req_addr", imem_req_addr, req_exp_pc);
        req_exp_pc = req_exp_pc + 64'd4;
        lat    = (mem_lat == 0) ? int'($urandom_range(4, 1)) : mem_lat;
        r.data = mem_word(imem_req_addr);
        r.due  = cyc + lat;
        pend_q.push_back(r);
      end
      @(posedge clk);
      cyc++;
      #1;
      if (!rst) pend_q.delete();
      if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
        r = pend_q.pop_front();
        imem_resp_valid = 1'b1;
        imem_resp_data  = r.data;
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
      end
    end
  end

  // Monitor: every accepted output must be the next entry of the expected stream.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (redirect_valid) begin
          check("redir_out_valid", out_valid, 0);
          check("redir_req_valid", imem_req_valid, 0);
        end
        if (out_valid && out_ready) begin
          out_cnt++;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL out_extra: got pc 0x%0h, expected no output", out_pc);
          end else begin
            e = exp_q.pop_front();
            check("out_pc", out_pc, e.pc);
            check("out_inst", out_inst, e.inst);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

  initial begin : stim
    int n, first_resp, first_out, c0, c1, a0, b0, k;
    rst = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    mem_lat = 1;
    load_stream(RST_PC);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_req_addr", imem_req_addr, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_inst", out_inst, 0);
    rst = 1'b1;

    // Phase 1: L=1, always ready; first-output latency and full throughput.
    first_resp = -1;
    first_out  = -1;
    c0 = 0;
    c1 = 0;
    for (n = 1; n <= 30; n++) begin
      @(posedge clk);
      if (n == 10) c0 = out_cnt;
      if (n == 30) c1 = out_cnt;
      @(negedge clk);
      if (first_resp < 0 && imem_resp_valid) first_resp = n;
      if (first_out < 0 && out_valid) first_out = n;
    end
`ifdef FETCH_BYPASS_EN
    check("first_out_cycle", first_out, 2);
    check("out_after_resp", first_out - first_resp, 0);
`else
    check("first_out_cycle", first_out, 3);
    check("out_after_resp", first_out - first_resp, 1);
`endif
    check("throughput_20", c1 - c0, 20);

    // Phase 2: restart at reset PC with decode stalled; credit caps at DEPTH.
    redirect(RST_PC);
    out_ready = 1'b0;
    a0 = acc_cnt;
    end_redirect();
    repeat (10) @(posedge clk);
    check("stall_reqs", acc_cnt - a0, DEPTH);
    @(negedge clk);
    check("stall_req_valid", imem_req_valid, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_head_pc", out_pc, RST_PC);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (30) @(posedge clk);

    // Phase 3: L=3 so several requests are in flight, then an odd redirect target.
    #1;
    mem_lat = 3;
    repeat (20) @(posedge clk);
    redirect(64'h8000_0101);
    end_redirect();
    repeat (30) @(posedge clk);

    // Phase 4: back-to-back redirects; only the second target may appear.
    redirect(64'h8000_0200);
    redirect(64'h8000_0300);
    end_redirect();
    repeat (30) @(posedge clk);

    // Phase 5: random ready on both sides, random latency, stream crossing address wrap.
    #1;
    mem_lat = 0;
    redirect(64'hFFFF_FFFF_FFFF_FF81);
    end_redirect();
    b0 = out_cnt;
    k = 0;
    while ((out_cnt - b0) < 200 && k < 4000) begin
      @(posedge clk); #1;
      imem_req_ready = ($urandom_range(1, 0) == 1);
      out_ready      = ($urandom_range(3, 0) != 0);
      k++;
    end
    check("random_200_done", (out_cnt - b0) >= 200, 1);
    imem_req_ready = 1'b1;
    out_ready = 1'b1;
    repeat (20) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
